// File: rtl/rs232_rx_ctrl_pkg.sv
// Shared definitions for the RS232 receive controller: register map,
// status/control bit positions and capture FSM encoding.
`timescale 1ns/1ps
package rs232_rx_ctrl_pkg;

    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_STAT = 1'b1;

    localparam int STAT_NE   = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_IE   = 3;

    localparam int CTL_FSEL  = 0;
    localparam int CTL_IE    = 1;
    localparam int CTL_CLR   = 2;
    localparam int CTL_FLUSH = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    // Field order mirrors the STAT_* bit positions, MSB first.
    typedef struct packed {
        logic [3:0] rsvd;
        logic       ie;
        logic       ovr;
        logic       full;
        logic       ne;
    } status_t;

endpackage

// File: rtl/rs232_rx_ctrl_fifo.sv
// Byte FIFO between the capture FSM and the CPU data register.
// Flush has priority; push while full is accepted when a pop lands in the same cycle.
`timescale 1ns/1ps
module rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/rs232_rx_ctrl.sv
// Drains the RS232 receiver through its rdy/done handshake into a FIFO and
// exposes a data and a status/control register to the CPU bus.
`timescale 1ns/1ps
module rs232_rx_ctrl
    import rs232_rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_done,
    output logic       fsel,
    input  logic       adr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t      state, nstate;
    logic        ie, overrun;
    logic [7:0]  head;
    logic [AW:0] count;
    logic        nonempty, full, pop, room, ctl_wr, flush, ovr_set;
    status_t     stat;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[7:4];

    assign nonempty = (count != '0);
    assign full     = (count == FULL_CNT);
    assign pop      = rd && (adr == ADR_DATA) && nonempty;
    assign room     = !full || pop;
    assign ctl_wr   = wr && (adr == ADR_STAT);
    assign flush    = ctl_wr && wdata[CTL_FLUSH];
    // A flushed byte is discarded on purpose, so it never counts as an overrun.
    assign ovr_set  = rx_done && !room && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:    if (rx_rdy) nstate = ST_CAPTURE;
            ST_CAPTURE: nstate = ST_WAIT;
            ST_WAIT:    if (!rx_rdy) nstate = ST_IDLE;
            default:    nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_done = (state == ST_CAPTURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsel    <= 1'b0;
            ie      <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (ctl_wr) begin
                fsel <= wdata[CTL_FSEL];
                ie   <= wdata[CTL_IE];
            end
            if (ovr_set)                        overrun <= 1'b1;
            else if (ctl_wr && wdata[CTL_CLR])  overrun <= 1'b0;
        end
    end

    rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_done),
        .pop   (pop),
        .flush (flush),
        .din   (rx_data),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        stat      = '0;
        stat.ie   = ie;
        stat.ovr  = overrun;
        stat.full = full;
        stat.ne   = nonempty;
        if (adr == ADR_DATA) rdata = nonempty ? head : 8'h00;
        else                 rdata = stat;
    end

    assign irq = ie && (nonempty || overrun);

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Directed bench: bus reads push expected values into a scoreboard queue,
// a monitor pops and compares whenever a read strobe is presented.
`timescale 1ns/1ps
module tb_rs232_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done;
    logic       fsel;
    logic       adr = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       irq;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    rs232_rx_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rx_done(rx_done), .fsel(fsel), .adr(adr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always @(negedge clk) if (rx_done) done_cnt++;

    // Monitor: every read strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rd) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: read adr=%0d got %02h with nothing expected", adr, rdata);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                automatic string      n = name_q.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL %s: got %02h expected %02h", n, rdata, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic start_read(input logic a, input logic [7:0] e, input string nm);
        adr = a;
        rd  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic rd_reg(input logic a, input logic [7:0] e, input string nm);
        @(posedge clk); #1 start_read(a, e, nm);
        @(posedge clk); #1 rd = 1'b0;
    endtask

    task automatic wr_ctl(input logic [7:0] v);
        @(posedge clk); #1 adr = 1'b1; wr = 1'b1; wdata = v;
        @(posedge clk); #1 wr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk); #1 rx_rdy = 1'b1; rx_data = b;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_done && n < 10);
        if (!rx_done) chk("handshake_timeout", {7'b0, rx_done}, 8'h01);
        @(posedge clk); #1 rx_rdy = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int d0;

        #22 rst = 1'b0;

        // Reset state
        #1 chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_fsel", {7'b0, fsel}, 8'h00);
        chk("rst_done", {7'b0, rx_done}, 8'h00);
        rd_reg(1'b1, 8'h00, "rst_status");
        rd_reg(1'b0, 8'h00, "rst_data");

        // Single byte 0x5A with handshake timing
        d0 = done_cnt;
        @(posedge clk); #1 rx_rdy = 1'b1; rx_data = 8'h5A;
        @(negedge clk) chk("done_n0", {7'b0, rx_done}, 8'h00);
        @(posedge clk); #1;
        @(negedge clk) chk("done_n1", {7'b0, rx_done}, 8'h01);
        @(posedge clk); #1 rx_rdy = 1'b0; start_read(1'b1, 8'h01, "single_status_n2");
        @(posedge clk); #1 rd = 1'b0;
        @(posedge clk);
        chk("single_done_pulses", 8'(done_cnt - d0), 8'h01);
        rd_reg(1'b0, 8'h5A, "single_data");
        rd_reg(1'b1, 8'h00, "single_status_after");

        // Fill and overrun: 17 bytes, no reads
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        rd_reg(1'b1, 8'h07, "ovr_status");
        for (int i = 0; i < 16; i++) rd_reg(1'b0, 8'(i), "ovr_data");
        rd_reg(1'b1, 8'h04, "ovr_status_drained");
        wr_ctl(8'h04);
        rd_reg(1'b1, 8'h00, "ovr_cleared");

        // Full FIFO, pop coincides with CAPTURE of 0xAB
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        @(posedge clk); #1 rx_rdy = 1'b1; rx_data = 8'hAB;
        @(posedge clk); #1 start_read(1'b0, 8'h20, "fullpop_head");
        @(negedge clk) chk("fullpop_done", {7'b0, rx_done}, 8'h01);
        @(posedge clk); #1 rd = 1'b0; rx_rdy = 1'b0;
        @(posedge clk);
        rd_reg(1'b1, 8'h03, "fullpop_status");
        for (int i = 1; i < 16; i++) rd_reg(1'b0, 8'h20 + 8'(i), "fullpop_data");
        rd_reg(1'b0, 8'hAB, "fullpop_last");
        rd_reg(1'b1, 8'h00, "fullpop_empty");

        // Control write 0x0B: fsel, ie, flush
        send_byte(8'h44);
        wr_ctl(8'h0B);
        chk("ctl_fsel", {7'b0, fsel}, 8'h01);
        chk("ctl_irq_flushed", {7'b0, irq}, 8'h00);
        rd_reg(1'b1, 8'h08, "ctl_status");
        send_byte(8'h77);
        #1 chk("ctl_irq_rise", {7'b0, irq}, 8'h01);
        rd_reg(1'b0, 8'h77, "ctl_data");
        chk("ctl_irq_fall", {7'b0, irq}, 8'h00);
        rd_reg(1'b0, 8'h00, "ctl_empty_data");
        rd_reg(1'b1, 8'h08, "ctl_empty_status");

        // Reset during WAIT with 3 bytes queued
        wr_ctl(8'h03);
        send_byte(8'h90);
        send_byte(8'h91);
        @(posedge clk); #1 rx_rdy = 1'b1; rx_data = 8'h92;
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        #1 chk("mrst_done", {7'b0, rx_done}, 8'h00);
        chk("mrst_fsel", {7'b0, fsel}, 8'h00);
        chk("mrst_irq", {7'b0, irq}, 8'h00);
        adr = 1'b0;
        #1 chk("mrst_data", rdata, 8'h00);
        adr = 1'b1;
        #1 chk("mrst_status", rdata, 8'h00);
        @(posedge clk); #3 rst = 1'b0;
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        #1 rx_rdy = 1'b0;
        @(posedge clk); @(posedge clk);
        chk("mrst_one_capture", 8'(done_cnt - d0), 8'h01);
        rd_reg(1'b1, 8'h01, "mrst_status_after");
        rd_reg(1'b0, 8'h92, "mrst_data_after");
        rd_reg(1'b0, 8'h00, "mrst_empty");

        // Flush coinciding with CAPTURE of 0x33 while full
        for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i));
        d0 = done_cnt;
        @(posedge clk); #1 rx_rdy = 1'b1; rx_data = 8'h33;
        @(posedge clk); #1 adr = 1'b1; wr = 1'b1; wdata = 8'h08;
        @(posedge clk); #1 wr = 1'b0; rx_rdy = 1'b0;
        @(posedge clk); @(posedge clk);
        chk("flush_done_pulses", 8'(done_cnt - d0), 8'h01);
        rd_reg(1'b1, 8'h00, "flush_status");
        rd_reg(1'b0, 8'h00, "flush_data");

        repeat (3) @(posedge clk);
        chk("sb_leftover", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
